ballot_collector: RTL and testbench
===================================

// Module: ballot_collector
// PURPOSE
//   Upstream producer for the 4-input vote classifier.
//   - Opens a timed voting window and collects one yes/no ballot per voter.
//   - Voters submit asynchronously to each other over per-voter valid strobes.
//   - Presents the assembled 4-bit ballot vector on a valid/ready handshake.
//   - The downstream stage is the classifier that sorts the vector into 0-1 / 2 / 3-4 yes votes.
// PARAMETERS
//   WINDOW  16  maximum cycles spent in OPEN before forced close (>=1)
//   CNT_W   derived localparam = $clog2(WINDOW+1); width of window timer
// PORTS
//   clk           in   1  single clock; all logic rising-edge
//   rst           in   1  synchronous, active-high reset
//   start         in   1  request to open a new ballot; honoured only in IDLE
//   vote_valid    in   4  bit i: voter i submits this cycle
//   vote_val      in   4  bit i: voter i's vote (1 = yes); sampled with vote_valid[i]
//   window_open   out  1  high while state == OPEN
//   voted         out  4  bit i: voter i has submitted in current ballot
//   ballot_out    out  4  assembled ballot; bit i = voter i's vote, abstain = 0
//   ballot_valid  out  1  ballot_out is complete and stable
//   ballot_ready  in   1  downstream accepts ballot when high with ballot_valid
//   timeout_flag  out  1  ballot closed by timer with at least one abstainer
//   dup_err       out  1  sticky per ballot: a voter submitted more than once
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; timer=0. rst wins over all other inputs.
//     Mid-OPEN or mid-PRESENT reset discards the ballot.
//   States: IDLE, OPEN, PRESENT.
//   IDLE:
//     - start=1 -> OPEN next cycle.
//     - Same edge: clear voted, ballot_out, timeout_flag, dup_err; timer <= WINDOW-1.
//     - vote_valid in IDLE is ignored.
//   OPEN (window_open=1):
//     - For each i with vote_valid[i] && !voted[i]: ballot_out[i] <= vote_val[i]; voted[i] <= 1.
//     - vote_valid[i] && voted[i]: vote ignored (first vote wins); dup_err <= 1.
//     - all_in = &(voted | (vote_valid & ~voted)), i.e. all voters in, counting this cycle's votes.
//     - all_in=1 -> PRESENT next cycle.
//     - Else timer==0 -> PRESENT next cycle; timeout_flag <= 1.
//     - Else timer decrements by 1.
//     - Votes arriving on the timer==0 cycle are accepted; timeout_flag only if still incomplete.
//     - OPEN lasts at most WINDOW cycles.
//   PRESENT:
//     - ballot_valid=1.
//     - ballot_out, voted, timeout_flag and dup_err held stable until handshake.
//     - ballot_valid && ballot_ready -> IDLE next cycle; ballot_valid drops that edge.
//     - start and vote_valid are ignored (no queuing).
//     - Flags persist in IDLE until the next start.
//   Latency:
//     - The vote completing the ballot in cycle t gives ballot_valid at t+1.
//     - Minimum start-to-ballot_valid is 2 cycles (start at t, all vote at t+1, valid at t+2).
//     - Back-to-back: after handshake at t, IDLE at t+1; start at t+1 reopens at t+2.
//   ballot_valid is deasserted in IDLE and OPEN; window_open and ballot_valid are never both 1.
// TESTING
//   1. start; votes v0=1,v1=0,v2=1,v3=1 on 4 successive cycles, ready=1
//      -> ballot_out=4'b1101, ballot_valid 1 cycle after v3, timeout_flag=0.
//   2. WINDOW=16; only v0=1, v2=1 vote
//      -> close after 16th OPEN cycle; ballot_out=4'b0101, voted=4'b0101, timeout_flag=1.
//   3. v1 votes 1 then 0 on a later cycle; others vote 0
//      -> ballot_out[1]=1, dup_err=1, ballot_out=4'b0010.
//   4. Complete ballot with ballot_ready=0 for 5 cycles, start pulsed meanwhile
//      -> ballot_valid/ballot_out stable, start ignored; ready=1 -> IDLE next cycle.
//   5. All four vote in one cycle, vote_val=4'b1111
//      -> PRESENT next cycle, ballot_out=4'b1111, voted=4'b1111.
//   6. rst asserted after 2 votes in OPEN
//      -> next cycle IDLE, all outputs 0; subsequent vote_valid without start ignored.

Source files
------------

// File: rtl/ballot_collector.sv
// Ballot collector: opens a timed voting window, gathers one yes/no vote per voter,
// and presents the assembled 4-bit ballot to the classifier over valid/ready.
module ballot_collector #(
  parameter int unsigned WINDOW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic       window_open,
  output logic [3:0] voted,
  output logic [3:0] ballot_out,
  output logic       ballot_valid,
  input  logic       ballot_ready,
  output logic       timeout_flag,
  output logic       dup_err
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       voted_q, voted_d;
  logic [3:0]       ballot_q, ballot_d;
  logic             timeout_q, timeout_d;
  logic             dup_q, dup_d;
  logic [3:0]       new_votes_c;

  // State and ballot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      voted_q   <= '0;
      ballot_q  <= '0;
      timeout_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      voted_q   <= voted_d;
      ballot_q  <= ballot_d;
      timeout_q <= timeout_d;
      dup_q     <= dup_d;
    end
  end

  // Next-state and ballot update
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    voted_d     = voted_q;
    ballot_d    = ballot_q;
    timeout_d   = timeout_q;
    dup_d       = dup_q;
    new_votes_c = vote_valid & ~voted_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_OPEN;
          timer_d   = CNT_W'(WINDOW - 1);
          voted_d   = '0;
          ballot_d  = '0;
          timeout_d = 1'b0;
          dup_d     = 1'b0;
        end
      end
      S_OPEN: begin
        // First vote per voter wins; repeats only raise the duplicate flag
        ballot_d = (ballot_q & ~new_votes_c) | (vote_val & new_votes_c);
        voted_d  = voted_q | new_votes_c;
        if (|(vote_valid & voted_q)) begin
          dup_d = 1'b1;
        end
        if (&voted_d) begin
          state_d = S_PRESENT;
        end else if (timer_q == '0) begin
          state_d   = S_PRESENT;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_PRESENT: begin
        if (ballot_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign window_open  = (state_q == S_OPEN);
  assign ballot_valid = (state_q == S_PRESENT);
  assign voted        = voted_q;
  assign ballot_out   = ballot_q;
  assign timeout_flag = timeout_q;
  assign dup_err      = dup_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Testbench for ballot_collector: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_ballot_collector;

  localparam int unsigned WINDOW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       window_open;
  logic [3:0] voted;
  logic [3:0] ballot_out;
  logic       ballot_valid;
  logic       ballot_ready;
  logic       timeout_flag;
  logic       dup_err;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 presenting
  int         m_phase;
  int         m_elapsed;
  logic [3:0] m_voted;
  logic [3:0] m_ballot;
  logic       m_to;
  logic       m_dup;

  ballot_collector #(.WINDOW(WINDOW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_val     (vote_val),
    .window_open  (window_open),
    .voted        (voted),
    .ballot_out   (ballot_out),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .timeout_flag (timeout_flag),
    .dup_err      (dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_voted = '0; m_ballot = '0; m_to = 0; m_dup = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_elapsed = 0; m_voted = '0; m_ballot = '0; m_to = 0; m_dup = 0;
      end
    end else if (m_phase == 1) begin
      m_elapsed++;
      for (int i = 0; i < 4; i++) begin
        if (vote_valid[i]) begin
          if (m_voted[i]) m_dup = 1'b1;
          else begin
            m_voted[i]  = 1'b1;
            m_ballot[i] = vote_val[i];
          end
        end
      end
      if (m_voted == 4'hF) m_phase = 2;
      else if (m_elapsed == WINDOW) begin
        m_phase = 2;
        m_to    = 1'b1;
      end
    end else begin
      if (ballot_ready) m_phase = 0;
    end
  endtask

  task automatic check_all();
    chk("window_open",  32'(window_open),  32'(m_phase == 1));
    chk("ballot_valid", 32'(ballot_valid), 32'(m_phase == 2));
    chk("voted",        32'(voted),        32'(m_voted));
    chk("ballot_out",   32'(ballot_out),   32'(m_ballot));
    chk("timeout_flag", 32'(timeout_flag), 32'(m_to));
    chk("dup_err",      32'(dup_err),      32'(m_dup));
  endtask

  // One clock: apply inputs, advance model on the edge, compare just after it
  task automatic cyc(input logic r, input logic s, input logic [3:0] vv,
                     input logic [3:0] vl, input logic rdy);
    rst = r; start = s; vote_valid = vv; vote_val = vl; ballot_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vote_valid = '0; vote_val = '0; ballot_ready = 1'b0;
    m_phase = 0; m_elapsed = 0; m_voted = '0; m_ballot = '0; m_to = 0; m_dup = 0;
    #1;
    cyc(1, 1, 4'hF, 4'hF, 1);
    chk("reset_outputs", 32'({window_open, voted, ballot_out, ballot_valid, timeout_flag, dup_err}), 32'd0);

    // Sequential votes, no timeout
    cyc(0, 1, 4'h0, 4'h0, 1);
    cyc(0, 0, 4'h1, 4'h1, 1);
    cyc(0, 0, 4'h2, 4'h0, 1);
    cyc(0, 0, 4'h4, 4'h4, 1);
    cyc(0, 0, 4'h8, 4'h8, 1);
    chk("t1_ballot",  32'(ballot_out), 32'h0000000D);
    chk("t1_valid",   32'(ballot_valid), 32'd1);
    chk("t1_timeout", 32'(timeout_flag), 32'd0);
    cyc(0, 0, 4'h0, 4'h0, 1);
    chk("t1_idle", 32'(ballot_valid), 32'd0);

    // Timeout with two voters in
    cyc(0, 1, 4'h0, 4'h0, 0);
    cyc(0, 0, 4'h5, 4'h5, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 4'h0, 0);
    chk("t2_open_at_15", 32'(window_open), 32'd1);
    cyc(0, 0, 4'h0, 4'h0, 0);
    chk("t2_valid",   32'(ballot_valid), 32'd1);
    chk("t2_ballot",  32'(ballot_out), 32'h5);
    chk("t2_voted",   32'(voted), 32'h5);
    chk("t2_timeout", 32'(timeout_flag), 32'd1);
    cyc(0, 0, 4'h0, 4'h0, 1);

    // Duplicate vote: first wins
    cyc(0, 1, 4'h0, 4'h0, 0);
    cyc(0, 0, 4'h2, 4'h2, 0);
    cyc(0, 0, 4'h2, 4'h0, 0);
    cyc(0, 0, 4'hD, 4'h0, 0);
    chk("t3_ballot", 32'(ballot_out), 32'h2);
    chk("t3_dup",    32'(dup_err), 32'd1);
    cyc(0, 0, 4'h0, 4'h0, 1);

    // Backpressure with start pulsed; flags persist into IDLE
    cyc(0, 1, 4'h0, 4'h0, 0);
    cyc(0, 0, 4'hF, 4'hA, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 4'hF, 4'h5, 0);
      chk("t4_hold_valid",  32'(ballot_valid), 32'd1);
      chk("t4_hold_ballot", 32'(ballot_out), 32'hA);
    end
    cyc(0, 0, 4'h0, 4'h0, 1);
    chk("t4_idle_valid",   32'(ballot_valid), 32'd0);
    chk("t4_idle_persist", 32'(ballot_out), 32'hA);

    // All in one cycle
    cyc(0, 1, 4'h0, 4'h0, 0);
    cyc(0, 0, 4'hF, 4'hF, 0);
    chk("t5_valid",  32'(ballot_valid), 32'd1);
    chk("t5_ballot", 32'(ballot_out), 32'hF);
    chk("t5_voted",  32'(voted), 32'hF);
    cyc(0, 0, 4'h0, 4'h0, 1);

    // Reset mid-OPEN
    cyc(0, 1, 4'h0, 4'h0, 0);
    cyc(0, 0, 4'h3, 4'h3, 0);
    cyc(1, 0, 4'h4, 4'h4, 0);
    chk("t6_reset", 32'({window_open, voted, ballot_out, ballot_valid, timeout_flag, dup_err}), 32'd0);
    cyc(0, 0, 4'hF, 4'hF, 0);
    cyc(0, 0, 4'hF, 4'hF, 1);
    chk("t6_ignored", 32'({window_open, voted, ballot_out}), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic       r, s, rdy;
      logic [3:0] vv, vl;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      vv  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 7) == 0) vv = 4'($urandom);
      vl  = 4'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      cyc(r, s, vv, vl, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
